// File: rtl/pipe_hazard_ctrl.sv
// Control-side sequencer for the 5-stage RISC-V pipeline: stages decode controls
// through ID/EX, EX/MEM, MEM/WB and resolves load-use stalls, redirects and forwarding.
module pipe_hazard_ctrl #(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           id_opcode,
  input  logic [2:0]           id_func3,
  input  logic [4:0]           id_rs1,
  input  logic [4:0]           id_rs2,
  input  logic [4:0]           id_rd,
  input  logic                 id_reg_write,
  input  logic                 id_mem_write,
  input  logic                 id_alu_src,
  input  logic                 id_branch,
  input  logic                 id_jump,
  input  logic [2:0]           id_mem_to_reg,
  input  logic [3:0]           id_alu_ctrl,
  input  logic                 ex_zero,
  input  logic                 ex_less,
  output logic                 pc_write_en,
  output logic                 if_id_write_en,
  output logic                 if_id_flush,
  output logic                 pc_sel,
  output logic                 ex_alu_src,
  output logic [3:0]           ex_alu_ctrl,
  output logic                 mem_mem_write,
  output logic [2:0]           mem_load_type,
  output logic                 wb_reg_write,
  output logic [2:0]           wb_mem_to_reg,
  output logic [4:0]           wb_rd,
  output logic [1:0]           fwd_a,
  output logic [1:0]           fwd_b,
  output logic [CNT_WIDTH-1:0] stall_cnt,
  output logic [CNT_WIDTH-1:0] flush_cnt
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [2:0] WB_LOAD  = 3'b011;

  // ID/EX
  logic       ex_reg_write, ex_mem_write, ex_branch, ex_jump;
  logic [2:0] ex_mem_to_reg, ex_func3;
  logic [4:0] ex_rd, ex_rs1, ex_rs2;
  // EX/MEM
  logic       mem_reg_write;
  logic [2:0] mem_mem_to_reg;
  logic [4:0] mem_rd;

  logic rs1_used, rs2_used, load_use, br_cond, take, stall, bubble;

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic m_we, input logic [4:0] m_rd,
                                         input logic w_we, input logic [4:0] w_rd);
    if (m_we && m_rd != '0 && m_rd == rs)      return 2'b01;
    else if (w_we && w_rd != '0 && w_rd == rs) return 2'b10;
    else                                        return 2'b00;
  endfunction

  always_comb begin
    rs1_used = !(id_opcode == OP_LUI || id_opcode == OP_AUIPC || id_opcode == OP_JAL);
    rs2_used = (id_opcode == OP_R || id_opcode == OP_S || id_opcode == OP_B);
    load_use = (ex_mem_to_reg == WB_LOAD) && (ex_rd != '0) &&
               ((rs1_used && ex_rd == id_rs1) || (rs2_used && ex_rd == id_rs2));
    case (ex_func3)
      3'b000:         br_cond = ex_zero;
      3'b001:         br_cond = !ex_zero;
      3'b100, 3'b110: br_cond = ex_less;
      3'b101, 3'b111: br_cond = !ex_less;
      default:        br_cond = 1'b0;
    endcase
    take   = ex_jump | (ex_branch & br_cond);
    // A redirect squashes the instruction that would have stalled.
    stall  = load_use & ~take;
    bubble = load_use | take;
    pc_write_en    = ~stall;
    if_id_write_en = ~stall;
    if_id_flush    = take;
    pc_sel         = take;
    fwd_a = fwd_sel(ex_rs1, mem_reg_write, mem_rd, wb_reg_write, wb_rd);
    fwd_b = fwd_sel(ex_rs2, mem_reg_write, mem_rd, wb_reg_write, wb_rd);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_reg_write   <= 1'b0;
      ex_mem_write   <= 1'b0;
      ex_alu_src     <= 1'b0;
      ex_branch      <= 1'b0;
      ex_jump        <= 1'b0;
      ex_mem_to_reg  <= '0;
      ex_alu_ctrl    <= '0;
      ex_func3       <= '0;
      ex_rd          <= '0;
      ex_rs1         <= '0;
      ex_rs2         <= '0;
      mem_reg_write  <= 1'b0;
      mem_mem_write  <= 1'b0;
      mem_mem_to_reg <= '0;
      mem_load_type  <= '0;
      mem_rd         <= '0;
      wb_reg_write   <= 1'b0;
      wb_mem_to_reg  <= '0;
      wb_rd          <= '0;
      stall_cnt      <= '0;
      flush_cnt      <= '0;
    end else begin
      // Bubbles clear the whole word so a squashed slot never forwards or hazards.
      if (bubble) begin
        ex_reg_write  <= 1'b0;
        ex_mem_write  <= 1'b0;
        ex_alu_src    <= 1'b0;
        ex_branch     <= 1'b0;
        ex_jump       <= 1'b0;
        ex_mem_to_reg <= '0;
        ex_alu_ctrl   <= '0;
        ex_func3      <= '0;
        ex_rd         <= '0;
        ex_rs1        <= '0;
        ex_rs2        <= '0;
      end else begin
        ex_reg_write  <= id_reg_write;
        ex_mem_write  <= id_mem_write;
        ex_alu_src    <= id_alu_src;
        ex_branch     <= id_branch;
        ex_jump       <= id_jump;
        ex_mem_to_reg <= id_mem_to_reg;
        ex_alu_ctrl   <= id_alu_ctrl;
        ex_func3      <= id_func3;
        ex_rd         <= id_rd;
        ex_rs1        <= id_rs1;
        ex_rs2        <= id_rs2;
      end
      mem_reg_write  <= ex_reg_write;
      mem_mem_write  <= ex_mem_write;
      mem_mem_to_reg <= ex_mem_to_reg;
      mem_load_type  <= ex_func3;
      mem_rd         <= ex_rd;
      wb_reg_write   <= mem_reg_write;
      wb_mem_to_reg  <= mem_mem_to_reg;
      wb_rd          <= mem_rd;
      if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_WIDTH'(1);
      if (take && flush_cnt != '1)  flush_cnt <= flush_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: an instruction-level pipeline model predicts
// every cycle's outputs; a monitor compares them on the falling edge.
module tb_pipe_hazard_ctrl;

  localparam int unsigned CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [6:0]    id_opcode;
  logic [2:0]    id_func3;
  logic [4:0]    id_rs1, id_rs2, id_rd;
  logic          id_reg_write, id_mem_write, id_alu_src, id_branch, id_jump;
  logic [2:0]    id_mem_to_reg;
  logic [3:0]    id_alu_ctrl;
  logic          ex_zero, ex_less;
  logic          pc_write_en, if_id_write_en, if_id_flush, pc_sel;
  logic          ex_alu_src;
  logic [3:0]    ex_alu_ctrl;
  logic          mem_mem_write;
  logic [2:0]    mem_load_type;
  logic          wb_reg_write;
  logic [2:0]    wb_mem_to_reg;
  logic [4:0]    wb_rd;
  logic [1:0]    fwd_a, fwd_b;
  logic [CW-1:0] stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset),
    .id_opcode(id_opcode), .id_func3(id_func3), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_write(id_mem_write), .id_alu_src(id_alu_src),
    .id_branch(id_branch), .id_jump(id_jump), .id_mem_to_reg(id_mem_to_reg),
    .id_alu_ctrl(id_alu_ctrl), .ex_zero(ex_zero), .ex_less(ex_less),
    .pc_write_en(pc_write_en), .if_id_write_en(if_id_write_en), .if_id_flush(if_id_flush),
    .pc_sel(pc_sel), .ex_alu_src(ex_alu_src), .ex_alu_ctrl(ex_alu_ctrl),
    .mem_mem_write(mem_mem_write), .mem_load_type(mem_load_type),
    .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg), .wb_rd(wb_rd),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011;
  localparam logic [6:0] OP_S = 7'b0100011, OP_B = 7'b1100011, OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;

  typedef struct packed {
    logic [6:0] op;
    logic [2:0] f3;
    logic [4:0] rs1, rs2, rd;
    logic       rw, mw, asrc, br, jp;
    logic [2:0] m2r;
    logic [3:0] actl;
  } ins_t;

  typedef struct packed {
    logic          pcw, ifw, flush, psel, asrc;
    logic [3:0]    actl;
    logic          mw;
    logic [2:0]    lt;
    logic          rw;
    logic [2:0]    m2r;
    logic [4:0]    rd;
    logic [1:0]    fa, fb;
    logic [CW-1:0] sc, fc;
  } obs_t;

  // In-flight instructions: [0]=EX, [1]=MEM, [2]=WB; an all-zero record is an empty slot.
  ins_t pipe [3];
  int   sc_m, fc_m;
  obs_t expq [$];
  int   checks = 0, failures = 0, cycle = 0;

  function automatic ins_t decode(input logic [6:0] op, input logic [4:0] rd,
                                  input logic [4:0] rs1, input logic [4:0] rs2,
                                  input logic [2:0] f3);
    ins_t i = '0;
    i.op = op; i.rd = rd; i.rs1 = rs1; i.rs2 = rs2; i.f3 = f3; i.actl = {1'b0, f3};
    case (op)
      OP_R:     i.rw = 1'b1;
      OP_I:     begin i.rw = 1'b1; i.asrc = 1'b1; end
      OP_LD:    begin i.rw = 1'b1; i.asrc = 1'b1; i.m2r = 3'b011; end
      OP_S:     begin i.mw = 1'b1; i.asrc = 1'b1; end
      OP_B:     i.br = 1'b1;
      OP_JAL:   begin i.rw = 1'b1; i.jp = 1'b1; i.m2r = 3'b010; end
      OP_JALR:  begin i.rw = 1'b1; i.jp = 1'b1; i.asrc = 1'b1; i.m2r = 3'b010; end
      OP_LUI:   begin i.rw = 1'b1; i.m2r = 3'b001; end
      OP_AUIPC: begin i.rw = 1'b1; i.m2r = 3'b100; end
      default:  i.rw = 1'b0;
    endcase
    return i;
  endfunction

  function automatic bit reads_rs1(input logic [6:0] op);
    return !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
  endfunction

  function automatic bit reads_rs2(input logic [6:0] op);
    return op == OP_R || op == OP_S || op == OP_B;
  endfunction

  function automatic bit branch_ok(input logic [2:0] f3, input logic z, input logic l);
    case (f3)
      3'b000: return z == 1'b1;
      3'b001: return z == 1'b0;
      3'b100, 3'b110: return l == 1'b1;
      3'b101, 3'b111: return l == 1'b0;
      default: return 1'b0;
    endcase
  endfunction

  // Youngest producer ahead of EX wins.
  function automatic logic [1:0] source_of(input logic [4:0] rs);
    if (rs == 5'd0) return 2'b00;
    if (pipe[1].rw && pipe[1].rd == rs) return 2'b01;
    if (pipe[2].rw && pipe[2].rd == rs) return 2'b10;
    return 2'b00;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cycle, act, req);
    end
  endtask

  // One clock: drive ID/EX inputs after the edge, predict outputs, then advance the model.
  task automatic step(input logic rst_v, input ins_t id, input logic z, input logic l,
                      output bit hz, output bit tk);
    obs_t e;
    ins_t x;
    bit   stl;
    @(posedge clk); #1;
    cycle++;
    reset = rst_v;
    id_opcode = id.op; id_func3 = id.f3; id_rs1 = id.rs1; id_rs2 = id.rs2; id_rd = id.rd;
    id_reg_write = id.rw; id_mem_write = id.mw; id_alu_src = id.asrc;
    id_branch = id.br; id_jump = id.jp; id_mem_to_reg = id.m2r; id_alu_ctrl = id.actl;
    ex_zero = z; ex_less = l;
    #1;
    if (!rst_v) begin
      for (int i = 0; i < 3; i++) pipe[i] = '0;
      sc_m = 0; fc_m = 0;
    end
    x   = pipe[0];
    hz  = x.m2r == 3'b011 && x.rd != 5'd0 &&
          ((reads_rs1(id.op) && x.rd == id.rs1) || (reads_rs2(id.op) && x.rd == id.rs2));
    tk  = x.jp || (x.br && branch_ok(x.f3, z, l));
    stl = hz && !tk;
    e.pcw = !stl; e.ifw = !stl; e.flush = tk; e.psel = tk;
    e.asrc = x.asrc; e.actl = x.actl;
    e.mw = pipe[1].mw; e.lt = pipe[1].f3;
    e.rw = pipe[2].rw; e.m2r = pipe[2].m2r; e.rd = pipe[2].rd;
    e.fa = source_of(x.rs1); e.fb = source_of(x.rs2);
    e.sc = CW'(sc_m); e.fc = CW'(fc_m);
    expq.push_back(e);
    if (rst_v) begin
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = (hz || tk) ? ins_t'('0) : id;
      if (stl) sc_m = (sc_m < CMAX) ? sc_m + 1 : CMAX;
      if (tk)  fc_m = (fc_m < CMAX) ? fc_m + 1 : CMAX;
    end
  endtask

  obs_t mon_e, mon_a;
  initial begin
    forever begin
      @(negedge clk);
      if (expq.size() != 0) begin
        mon_e = expq.pop_front();
        mon_a = {pc_write_en, if_id_write_en, if_id_flush, pc_sel, ex_alu_src, ex_alu_ctrl,
                 mem_mem_write, mem_load_type, wb_reg_write, wb_mem_to_reg, wb_rd,
                 fwd_a, fwd_b, stall_cnt, flush_cnt};
        check("hazard_ctl", {mon_a.pcw, mon_a.ifw, mon_a.flush, mon_a.psel},
                            {mon_e.pcw, mon_e.ifw, mon_e.flush, mon_e.psel});
        check("ex_stage",  {mon_a.asrc, mon_a.actl}, {mon_e.asrc, mon_e.actl});
        check("mem_stage", {mon_a.mw, mon_a.lt}, {mon_e.mw, mon_e.lt});
        check("wb_stage",  {mon_a.rw, mon_a.m2r, mon_a.rd}, {mon_e.rw, mon_e.m2r, mon_e.rd});
        check("fwd",       {mon_a.fa, mon_a.fb}, {mon_e.fa, mon_e.fb});
        check("stall_cnt", 32'(mon_a.sc), 32'(mon_e.sc));
        check("flush_cnt", 32'(mon_a.fc), 32'(mon_e.fc));
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog cycle=%0d actual=timeout required=finish", cycle);
    $fatal(1, "watchdog");
  end

  initial begin
    ins_t nop, lw5, use5, jw, cur;
    ins_t ops_tab [9];
    logic [6:0] opl [9];
    bit hz, tk, rst_r;
    nop  = decode(OP_I, 5'd0, 5'd0, 5'd0, 3'b000);
    lw5  = decode(OP_LD, 5'd5, 5'd2, 5'd0, 3'b010);
    use5 = decode(OP_R, 5'd6, 5'd5, 5'd7, 3'b000);
    opl  = '{OP_R, OP_I, OP_LD, OP_S, OP_B, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
    ops_tab = '{default: '0};
    reset = 1'b0;
    for (int i = 0; i < 3; i++) pipe[i] = '0;
    sc_m = 0; fc_m = 0;

    repeat (3) step(1'b0, nop, 1'b0, 1'b0, hz, tk);
    step(1'b1, nop, 1'b0, 1'b0, hz, tk);
    check("rst_pc_write_en", 32'(pc_write_en), 32'd1);
    check("rst_stall_cnt", 32'(stall_cnt), 32'd0);

    // Load followed by a dependent add: one stall, then WB forwarding.
    step(1'b1, lw5, 1'b0, 1'b0, hz, tk);
    step(1'b1, use5, 1'b0, 1'b0, hz, tk);
    check("lu_stall", {pc_write_en, if_id_write_en}, 2'b00);
    step(1'b1, use5, 1'b0, 1'b0, hz, tk);
    check("lu_release", {pc_write_en, if_id_write_en}, 2'b11);
    step(1'b1, nop, 1'b0, 1'b0, hz, tk);
    check("lu_fwd_a", 32'(fwd_a), 32'd2);
    check("lu_stall_cnt", 32'(stall_cnt), 32'd1);

    // MEM forwarding on both operands, and none for x0.
    step(1'b1, decode(OP_R, 5'd1, 5'd3, 5'd4, 3'b000), 1'b0, 1'b0, hz, tk);
    step(1'b1, decode(OP_R, 5'd2, 5'd1, 5'd1, 3'b000), 1'b0, 1'b0, hz, tk);
    step(1'b1, nop, 1'b0, 1'b0, hz, tk);
    check("mem_fwd", {fwd_a, fwd_b}, 4'b0101);
    step(1'b1, decode(OP_R, 5'd0, 5'd3, 5'd4, 3'b000), 1'b0, 1'b0, hz, tk);
    step(1'b1, decode(OP_R, 5'd2, 5'd0, 5'd0, 3'b000), 1'b0, 1'b0, hz, tk);
    step(1'b1, nop, 1'b0, 1'b0, hz, tk);
    check("x0_fwd", {fwd_a, fwd_b}, 4'b0000);

    // beq taken, then beq not taken.
    step(1'b1, decode(OP_B, 5'd0, 5'd1, 5'd2, 3'b000), 1'b0, 1'b0, hz, tk);
    step(1'b1, nop, 1'b1, 1'b0, hz, tk);
    check("beq_redirect", {pc_sel, if_id_flush}, 2'b11);
    step(1'b1, nop, 1'b0, 1'b0, hz, tk);
    check("beq_once", {pc_sel, if_id_flush}, 2'b00);
    check("beq_flush_cnt", 32'(flush_cnt), 32'd1);
    step(1'b1, decode(OP_B, 5'd0, 5'd1, 5'd2, 3'b000), 1'b0, 1'b0, hz, tk);
    step(1'b1, nop, 1'b0, 1'b0, hz, tk);
    check("beq_not_taken", 32'(pc_sel), 32'd0);

    // A jump whose control word also marks a load: redirect beats the stall.
    jw = decode(OP_JAL, 5'd5, 5'd0, 5'd0, 3'b000);
    jw.m2r = 3'b011;
    step(1'b1, jw, 1'b0, 1'b0, hz, tk);
    step(1'b1, use5, 1'b0, 1'b0, hz, tk);
    check("jal_over_stall", {pc_write_en, pc_sel}, 2'b11);
    step(1'b1, nop, 1'b0, 1'b0, hz, tk);
    check("jal_stall_cnt", 32'(stall_cnt), 32'd1);
    check("jal_flush_cnt", 32'(flush_cnt), 32'd2);

    // Saturation: 19 more stalls on a 4-bit counter.
    repeat (19) begin
      step(1'b1, lw5, 1'b0, 1'b0, hz, tk);
      step(1'b1, use5, 1'b0, 1'b0, hz, tk);
      step(1'b1, use5, 1'b0, 1'b0, hz, tk);
    end
    step(1'b1, nop, 1'b0, 1'b0, hz, tk);
    check("stall_sat", 32'(stall_cnt), 32'(CMAX));

    // Mid-run reset clears immediately.
    step(1'b1, lw5, 1'b0, 1'b0, hz, tk);
    step(1'b0, use5, 1'b0, 1'b0, hz, tk);
    check("midrst_cnt", {stall_cnt, flush_cnt}, 8'h00);
    check("midrst_ctl", {pc_write_en, if_id_write_en, wb_reg_write, fwd_a, fwd_b}, 7'b1100000);

    // Random instruction stream with IF/ID hold and flush emulation.
    cur = nop;
    for (int n = 0; n < 600; n++) begin
      rst_r = ($urandom_range(0, 199) != 0);
      step(rst_r, cur, 1'($urandom), 1'($urandom), hz, tk);
      if (rst_r && tk)       cur = nop;
      else if (rst_r && hz)  cur = cur;
      else cur = decode(opl[$urandom_range(0, 8)], 5'($urandom_range(0, 7)),
                        5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 3'($urandom));
    end

    for (int k = 0; k < 10 && expq.size() != 0; k++) @(posedge clk);
    if (expq.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain actual=%0d required=0", expq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Control-side sequencer for the 5-stage RISC-V data_path. It carries main_control's decode-stage control word through ID/EX, EX/MEM and MEM/WB control registers. It detects load-use hazards and stalls, resolves branches and jumps in EX and flushes, and generates EX-stage forwarding selects. It also keeps saturating stall and flush counters for bring-up.

Parameters:
- CNT_WIDTH, 16, width of the stall_cnt and flush_cnt performance counters.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous active-low reset
- id_opcode  in  7  opcode of the instruction in ID
- id_func3  in  3  func3 of the instruction in ID
- id_rs1  in  5  rs1 field of the instruction in ID
- id_rs2  in  5  rs2 field of the instruction in ID
- id_rd  in  5  rd field of the instruction in ID
- id_reg_write, id_mem_write, id_alu_src, id_branch, id_jump  in  1 each  decode controls from main_control
- id_mem_to_reg  in  3  writeback select from main_control (3'b011 = load data)
- id_alu_ctrl  in  4  ALU operation from main_control
- ex_zero  in  1  ALU zero flag in EX
- ex_less  in  1  ALU less flag in EX
- pc_write_en  out  1  PC load enable
- if_id_write_en  out  1  IF/ID register load enable
- if_id_flush  out  1  IF/ID register clear to NOP (32'h00000013)
- pc_sel  out  1  1 = select EX branch/jump target
- ex_alu_src  out  1  staged control, EX stage
- ex_alu_ctrl  out  4  staged control, EX stage
- mem_mem_write  out  1  staged control, MEM stage
- mem_load_type  out  3  staged func3, MEM stage
- wb_reg_write  out  1  staged control, WB stage
- wb_mem_to_reg  out  3  staged control, WB stage
- wb_rd  out  5  destination register, WB stage
- fwd_a, fwd_b  out  2 each  ALU operand forwarding select: 00 = register file, 01 = EX/MEM ALU result, 10 = WB data
- stall_cnt  out  CNT_WIDTH  saturating count of load-use stall cycles
- flush_cnt  out  CNT_WIDTH  saturating count of taken redirects

Behaviour:
- Reset: all stage registers and both counters clear to 0. With reset deasserted, pc_write_en=1, if_id_write_en=1, if_id_flush=0, pc_sel=0, fwd_a=fwd_b=00. Asserting reset mid-operation clears everything immediately, with no partial state kept.
- Register uses:
  - rs1 is used unless id_opcode is LUI 0110111, AUIPC 0010111 or JAL 1101111.
  - rs2 is used only for R 0110011, S 0100011 and B 1100011.
- Pipeline advance: every clock edge, ID→EX→MEM→WB control registers advance, carrying rd, rs1, rs2 and func3 with them. No stage ever holds except under the load-use rule below.
- Load-use hazard (combinational):
  - Condition: ex_mem_to_reg==3'b011, ex_rd!=0, and ex_rd matches a used id_rs1 or id_rs2.
  - Response: pc_write_en=0 and if_id_write_en=0. ID/EX loads a bubble at the next edge (all write/branch/jump controls 0, rd=0).
  - Exactly one stall cycle per hazard.
- Branch resolution (combinational, EX stage):
  - Branch condition by func3: 000 = zero, 001 = !zero, 100 and 110 = less, 101 and 111 = !less, any other value = not taken.
  - take = ex_jump | (ex_branch & branch condition).
  - When take=1: pc_sel=1, if_id_flush=1, and ID/EX loads a bubble at the next edge. Total penalty is 2 cycles.
- Priority: take overrides a load-use stall in the same cycle. In that case pc_write_en=1 and stall_cnt does not increment, because the stalled instruction is squashed.
- Forwarding (per operand, shown for fwd_a; fwd_b is the same using ex_rs2):
  - 01 if mem_reg_write, mem_rd!=0 and mem_rd==ex_rs1.
  - else 10 if wb_reg_write, wb_rd!=0 and wb_rd==ex_rs1.
  - else 00. The MEM stage wins when both match.
- Counters: stall_cnt increments on each stall cycle and flush_cnt on each take cycle. Both saturate at all-ones.
- Out of scope: a WB→ID same-cycle read is handled by register_file write-before-read.

Test Plan:
- Reset held low 3 cycles, then released → all staged outputs 0, pc_write_en=1, counters 0. Reset pulsed mid-run → immediate clear.
- lw x5 then add x6,x5,x7 → one cycle with pc_write_en=0 and if_id_write_en=0. Bubble in EX (ex_reg_write=0), then fwd_a=10 for the add, stall_cnt=1.
- add x1 then sub x2,x1,x1 → fwd_a=01 and fwd_b=01 in the sub's EX cycle. Writing x0 instead → fwd selects remain 00.
- beq with ex_zero=1 → pc_sel=1 and if_id_flush=1 for one cycle, next EX is a bubble, flush_cnt=1. Same case with ex_zero=0 → no redirect.
- Load-use hazard coincident with a taken jal in EX → pc_write_en=1, pc_sel=1, stall_cnt unchanged, flush_cnt increments.
- Force 2^CNT_WIDTH+3 stalls → stall_cnt holds at all-ones.
